// File: rtl/axi_lite_slave_regs_if.sv
// axi_lite_slave_regs_if: AXI-Lite bus bundle between a master and the register slave.
interface axi_lite_slave_regs_if #(parameter int ADDR_WIDTH = 32);
    logic [ADDR_WIDTH-1:0] AWADDR;
    logic                  AWVALID;
    logic                  AWREADY;
    logic [31:0]           WDATA;
    logic [3:0]            WSTRB;
    logic                  WVALID;
    logic                  WREADY;
    logic [1:0]            BRESP;
    logic                  BVALID;
    logic                  BREADY;
    logic [ADDR_WIDTH-1:0] ARADDR;
    logic                  ARVALID;
    logic                  ARREADY;
    logic [31:0]           RDATA;
    logic [1:0]            RRESP;
    logic                  RVALID;
    logic                  RREADY;
    modport master (
        output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );
    modport slave (
        input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );
endinterface

// File: rtl/axi_lite_slave_regs.sv
// axi_lite_slave_regs: AXI-Lite slave terminating into NUM_REGS 32-bit registers.
// Define AXIL_SLAVE_ERR_RESP_EN to answer out-of-range accesses with SLVERR.
module axi_lite_slave_regs #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    axi_lite_slave_regs_if.slave    bus,
    output logic [NUM_REGS*32-1:0]  reg_out,
    output logic [NUM_REGS-1:0]     reg_wr
);
    localparam int IDX_W = $clog2(NUM_REGS);
    localparam int NB = DATA_WIDTH / 8;
`ifdef AXIL_SLAVE_ERR_RESP_EN
    localparam logic [1:0] OOR_RESP = 2'b10;
`else
    localparam logic [1:0] OOR_RESP = 2'b00;
`endif
    typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_RESP} r_state_t;
    w_state_t ws, ws_n;
    r_state_t rs, rs_n;
    logic up, aw_done, w_done, aw_hs, w_hs, ar_hs, wr_en;
    logic [ADDR_WIDTH-1:2] aw_addr;
    logic [DATA_WIDTH-1:0] w_data;
    logic [NB-1:0] w_strb;
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    function automatic logic in_range(input logic [ADDR_WIDTH-1:2] a);
        return 32'(a[IDX_W+1:2]) < NUM_REGS && (a >> IDX_W) == '0;
    endfunction

    assign aw_hs = bus.AWVALID && bus.AWREADY;
    assign w_hs  = bus.WVALID && bus.WREADY;
    assign ar_hs = bus.ARVALID && bus.ARREADY;

    // up holds every ready low until the first edge after reset is released
    always_ff @(posedge clk) begin
        ws <= rst ? W_IDLE : ws_n;
        rs <= rst ? R_IDLE : rs_n;
        up <= !rst;
    end

    always_comb begin
        ws_n = ws == W_IDLE ? ((aw_done || aw_hs) && (w_done || w_hs) ? W_EXEC : W_IDLE)
             : ws == W_EXEC ? W_RESP
             : bus.BREADY ? W_IDLE : W_RESP;
        rs_n = rs == R_IDLE ? (ar_hs ? R_RESP : R_IDLE) : bus.RREADY ? R_IDLE : R_RESP;
    end

    always_comb begin
        bus.AWREADY = up && ws == W_IDLE && !aw_done;
        bus.WREADY  = up && ws == W_IDLE && !w_done;
        bus.BVALID  = ws == W_RESP;
        bus.ARREADY = up && rs == R_IDLE;
        bus.RVALID  = rs == R_RESP;
        wr_en       = ws == W_EXEC && in_range(aw_addr);
        reg_wr      = wr_en ? NUM_REGS'(1) << aw_addr[IDX_W+1:2] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            bus.BRESP <= 2'b00;
        end else begin
            if (aw_hs) begin
                aw_addr <= bus.AWADDR[ADDR_WIDTH-1:2];
                aw_done <= 1'b1;
            end
            if (w_hs) begin
                w_data <= bus.WDATA;
                w_strb <= bus.WSTRB;
                w_done <= 1'b1;
            end
            if (ws == W_EXEC) begin
                aw_done   <= 1'b0;
                w_done    <= 1'b0;
                bus.BRESP <= in_range(aw_addr) ? 2'b00 : OOR_RESP;
            end
        end
    end

    // a read accepted during W_EXEC samples the bank before this edge's write lands
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.RDATA <= '0;
            bus.RRESP <= 2'b00;
        end else if (ar_hs) begin
            bus.RDATA <= in_range(bus.ARADDR[ADDR_WIDTH-1:2]) ? regs[bus.ARADDR[IDX_W+1:2]] : '0;
            bus.RRESP <= in_range(bus.ARADDR[ADDR_WIDTH-1:2]) ? 2'b00 : OOR_RESP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wr_en) begin
            for (int b = 0; b < NB; b++)
                if (w_strb[b]) regs[aw_addr[IDX_W+1:2]][8*b +: 8] <= w_data[8*b +: 8];
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_out
        assign reg_out[32*i +: 32] = regs[i];
    end
endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// tb_axi_lite_slave_regs: directed plus randomized checks of the AXI-Lite register slave
// against a byte-level register model.
module tb_axi_lite_slave_regs;
    localparam int NR = 8;
`ifdef AXIL_SLAVE_ERR_RESP_EN
    localparam logic [1:0] ERR = 2'b10;
`else
    localparam logic [1:0] ERR = 2'b00;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NR*32-1:0] reg_out;
    logic [NR-1:0] reg_wr;
    int checks = 0;
    int errors = 0;
    logic [31:0] mdl [NR];
    int wr_cyc, b_hs, bv_cyc;
    logic [NR-1:0] wr_or;

    axi_lite_slave_regs_if #(.ADDR_WIDTH(32)) bus ();
    axi_lite_slave_regs #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(NR)) dut (
        .clk(clk), .rst(rst), .bus(bus), .reg_out(reg_out), .reg_wr(reg_wr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reg_wr != '0) begin
            wr_cyc++;
            wr_or |= reg_wr;
        end
        if (bus.BVALID) bv_cyc++;
        if (bus.BVALID && bus.BREADY) b_hs++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NR*32-1:0] packed_mdl();
        logic [NR*32-1:0] r;
        for (int i = 0; i < NR; i++) r[32*i +: 32] = mdl[i];
        return r;
    endfunction

    function automatic bit ok(input logic [31:0] a);
        return a < 32'(4 * NR);
    endfunction

    task automatic aw_w(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input int aw_dly, input int w_dly);
        bit ad = 0;
        bit wd = 0;
        int cyc = 0;
        bus.AWADDR = a;
        bus.WDATA = d;
        bus.WSTRB = s;
        while (!(ad && wd)) begin
            bus.AWVALID = !ad && cyc >= aw_dly;
            bus.WVALID = !wd && cyc >= w_dly;
            @(negedge clk);
            if (wd && !ad) chk("wready_hold", bus.WREADY, 0);
            if (ad && !wd) chk("awready_hold", bus.AWREADY, 0);
            ad |= bus.AWVALID && bus.AWREADY;
            wd |= bus.WVALID && bus.WREADY;
            @(posedge clk); #1;
            if (++cyc > 50) begin
                chk("aw_w_timeout", 1, 0);
                break;
            end
        end
        bus.AWVALID = 0;
        bus.WVALID = 0;
    endtask

    task automatic b_phase(input int b_dly, output logic [1:0] resp);
        int n = 0;
        bus.BREADY = b_dly == 0;
        @(negedge clk);
        while (!bus.BVALID && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("bvalid_seen", bus.BVALID, 1);
        resp = bus.BRESP;
        for (int k = 0; k < b_dly; k++) begin
            @(posedge clk); #1;
            chk("b_stable", {bus.BVALID, bus.BRESP, bus.AWREADY, bus.WREADY}, {1'b1, resp, 2'b00});
        end
        bus.BREADY = 1;
        @(posedge clk); #1;
        bus.BREADY = 0;
        chk("b_done", {bus.BVALID, bus.AWREADY, bus.WREADY}, 3'b011);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly, input int b_dly);
        logic [1:0] resp;
        logic [NR-1:0] exp_wr;
        wr_cyc = 0;
        wr_or = '0;
        b_hs = 0;
        bv_cyc = 0;
        aw_w(a, d, s, aw_dly, w_dly);
        b_phase(b_dly, resp);
        exp_wr = ok(a) ? NR'(1) << (a / 4) : '0;
        if (ok(a))
            for (int b = 0; b < 4; b++)
                if (s[b]) mdl[a / 4][8*b +: 8] = d[8*b +: 8];
        chk("bresp", resp, ok(a) ? 2'b00 : ERR);
        chk("reg_wr", wr_or, exp_wr);
        chk("reg_wr_cycles", wr_cyc, ok(a) ? 1 : 0);
        chk("b_count", b_hs, 1);
        chk("bvalid_cycles", bv_cyc, b_dly + 1);
        chk("reg_out", reg_out, packed_mdl());
    endtask

    task automatic ar_phase(input logic [31:0] a);
        int n = 0;
        bus.ARADDR = a;
        bus.ARVALID = 1;
        @(negedge clk);
        while (!bus.ARREADY && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("arready_seen", bus.ARREADY, 1);
        @(posedge clk); #1;
        bus.ARVALID = 0;
        chk("rvalid_rise", {bus.RVALID, bus.ARREADY}, 2'b10);
    endtask

    task automatic r_phase(input int r_dly, output logic [31:0] data, output logic [1:0] resp);
        data = bus.RDATA;
        resp = bus.RRESP;
        for (int k = 0; k < r_dly; k++) begin
            @(posedge clk); #1;
            chk("r_stable", {bus.RVALID, bus.RDATA, bus.RRESP, bus.ARREADY}, {1'b1, data, resp, 1'b0});
        end
        bus.RREADY = 1;
        @(posedge clk); #1;
        bus.RREADY = 0;
        chk("r_done", {bus.RVALID, bus.ARREADY}, 2'b01);
    endtask

    task automatic do_read(input logic [31:0] a, input int r_dly);
        logic [31:0] d;
        logic [1:0] r;
        bus.RREADY = r_dly == 0;
        ar_phase(a);
        r_phase(r_dly, d, r);
        chk("rdata", d, ok(a) ? mdl[a / 4] : 32'h0);
        chk("rresp", r, ok(a) ? 2'b00 : ERR);
    endtask

    initial begin
        logic [31:0] a, d;
        logic [1:0] r;
        int n;
        {bus.AWADDR, bus.AWVALID, bus.WDATA, bus.WSTRB, bus.WVALID, bus.BREADY} = '0;
        {bus.ARADDR, bus.ARVALID, bus.RREADY} = '0;
        for (int i = 0; i < NR; i++) mdl[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {bus.AWREADY, bus.WREADY, bus.ARREADY, bus.BVALID, bus.RVALID,
                              bus.BRESP, bus.RRESP, bus.RDATA, reg_wr}, 0);
        chk("reset_regs", reg_out, 0);
        rst = 0;
        @(posedge clk); #1;
        chk("ready_after_reset", {bus.AWREADY, bus.WREADY, bus.ARREADY}, 3'b111);

        do_write(32'h4, 32'hDEADBEEF, 4'hF, 0, 0, 0);
        chk("reg1_value", reg_out[63:32], 32'hDEADBEEF);
        do_read(32'h4, 0);

        do_write(32'h8, 32'h11223344, 4'h5, 3, 0, 0);
        chk("reg2_value", reg_out[95:64], 32'h00220044);

        do_write(32'hC, 32'hA5A55A5A, 4'hF, 0, 0, 5);
        do_read(32'hC, 4);
        do_write(32'h10, 32'hFFFFFFFF, 4'h0, 1, 2, 0);

        do_write(32'h20, 32'h12345678, 4'hF, 0, 0, 0);
        do_read(32'h100, 0);
        do_write(32'h1000_0004, 32'h87654321, 4'hF, 0, 1, 1);
        do_read(32'h1000_0008, 2);

        bus.AWADDR = 32'h0;
        bus.WDATA = 32'hCAFEF00D;
        bus.WSTRB = 4'hF;
        bus.AWVALID = 1;
        bus.WVALID = 1;
        bus.BREADY = 1;
        @(posedge clk); #1;
        bus.AWVALID = 0;
        bus.WVALID = 0;
        bus.ARADDR = 32'h0;
        bus.ARVALID = 1;
        bus.RREADY = 0;
        @(negedge clk);
        chk("collide_exec", {reg_wr[0], bus.ARREADY}, 2'b11);
        @(posedge clk); #1;
        bus.ARVALID = 0;
        chk("collide_old", {bus.RVALID, bus.RDATA}, {1'b1, 32'h0});
        mdl[0] = 32'hCAFEF00D;
        chk("collide_reg", reg_out, packed_mdl());
        r_phase(0, d, r);
        bus.BREADY = 0;
        do_read(32'h0, 0);

        repeat (40) begin
            a = ($urandom_range(0, 3) == 0) ? (32'h1000_0000 | 32'($urandom_range(0, 7) * 4))
                                            : 32'($urandom_range(0, 4 * NR + 11));
            if ($urandom_range(0, 1) == 0)
                do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                         $urandom_range(0, 3), $urandom_range(0, 3));
            else
                do_read(a, $urandom_range(0, 3));
        end

        bus.RREADY = 0;
        ar_phase(32'h4);
        aw_w(32'h8, 32'h55, 4'hF, 0, 0);
        bus.BREADY = 0;
        n = 0;
        @(negedge clk);
        while (!bus.BVALID && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("pre_reset_valids", {bus.BVALID, bus.RVALID}, 2'b11);
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        for (int i = 0; i < NR; i++) mdl[i] = '0;
        chk("mid_reset_outputs", {bus.AWREADY, bus.WREADY, bus.ARREADY, bus.BVALID, bus.RVALID,
                                  bus.BRESP, bus.RRESP, bus.RDATA, reg_wr}, 0);
        chk("mid_reset_regs", reg_out, 0);
        @(posedge clk); #1;
        chk("ready_after_mid_reset", {bus.AWREADY, bus.WREADY, bus.ARREADY, bus.BVALID, bus.RVALID}, 5'b11100);
        do_write(32'h1C, 32'h0BADF00D, 4'hC, 0, 0, 0);
        do_read(32'h1C, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/axi_lite_slave_regs.md
Name: axi_lite_slave_regs

Overview:
- AXI-Lite responder that terminates the five AXI-Lite channels into a bank of NUM_REGS read/write registers.
- Serves as the target for the team's AXI-Lite master in block-level benches.
- Exposes the register contents and per-register write strobes to local logic.
- Supports one outstanding write and one outstanding read; the write and read paths are independent.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 32, data width; fixed at 32 (WSTRB is 4 bits).
- NUM_REGS, 8, number of 32-bit registers, range 2..256; register i is at byte address 4*i.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- AWADDR  input  ADDR_WIDTH  write address.
- AWVALID  input  1.
- AWREADY  output  1.
- WDATA  input  32.
- WSTRB  input  4  byte strobes.
- WVALID  input  1.
- WREADY  output  1.
- BRESP  output  2.
- BVALID  output  1.
- BREADY  input  1.
- ARADDR  input  ADDR_WIDTH.
- ARVALID  input  1.
- ARREADY  output  1.
- RDATA  output  32.
- RRESP  output  2.
- RVALID  output  1.
- RREADY  input  1.
- reg_out  output  NUM_REGS*32  flattened register contents; reg i occupies bits [32*i+31:32*i].
- reg_wr  output  NUM_REGS  one-cycle one-hot pulse marking the register written that cycle.

Behaviour:
- Reset (rst=1 at a clock edge):
  - All outputs go to 0 (AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP, RDATA, reg_wr) and all registers clear to 0.
  - Any in-flight transaction is dropped; no response is issued for it.
  - Ready signals rise on the first clock edge after rst deasserts.
- Address decode:
  - idx = addr[IDX_W+1:2], where IDX_W = clog2(NUM_REGS).
  - The address is in range iff idx < NUM_REGS and all addr bits above IDX_W+1 are 0.
  - addr[1:0] is ignored.
- Write FSM, states W_IDLE, W_EXEC, W_RESP:
  - W_IDLE:
    - AWREADY=1 until the AW handshake, then AWREADY=0 and AWADDR is latched.
    - WREADY=1 until the W handshake, then WREADY=0 and WDATA/WSTRB are latched.
    - AW and W may complete in the same cycle or in either order.
    - Move to W_EXEC in the cycle after both are captured.
  - W_EXEC:
    - For an in-range address, update register bytes where WSTRB[b]=1, leaving the other bytes unchanged, and pulse reg_wr[idx] for this one cycle.
    - Set BVALID=1 and BRESP, then go to W_RESP.
  - W_RESP:
    - Hold BVALID and BRESP stable until BREADY=1.
    - On the handshake, clear BVALID and go to W_IDLE; AWREADY and WREADY reassert the next cycle.
  - Minimum latency: 1 cycle from the last of AW/W handshake to register update; 2 cycles to BVALID.
- Read FSM, states R_IDLE, R_RESP:
  - R_IDLE: ARREADY=1.
  - On the AR handshake, on the next edge ARREADY drops, RDATA is loaded with the current value of reg[idx], RRESP is set, and RVALID rises.
  - R_RESP: hold RDATA, RRESP and RVALID until RREADY=1; ARREADY reasserts the cycle after the handshake.
  - An RREADY already high when RVALID rises completes in 1 cycle.
- Read/write collision: an AR handshake in the same cycle as the W_EXEC update returns the old register value.
- WSTRB=0: no bytes change and reg_wr still pulses; BRESP=OKAY.
- Out-of-range access behaviour is set by the optional feature below.

Optional Feature:
- Macro: AXIL_SLAVE_ERR_RESP_EN.
- Defined:
  - An out-of-range write updates nothing, pulses no reg_wr, and returns BRESP=2'b10 (SLVERR).
  - An out-of-range read returns RDATA=0 with RRESP=2'b10.
- Undefined:
  - Out-of-range writes are silently dropped with BRESP=2'b00.
  - Out-of-range reads return RDATA=0 with RRESP=2'b00.
- In-range accesses always return 2'b00.

Test Plan:
- AW and W together (addr 0x4, data 0xDEADBEEF, strb 0xF), BREADY=1:
  - reg_wr=8'b0000_0010 for one cycle and reg_out[63:32]=0xDEADBEEF.
  - BVALID is high for 1 cycle with BRESP=00.
  - A read of 0x4 then returns 0xDEADBEEF with RRESP=00.
- W first (data 0x11223344, strb 0x5), then AW to 0x8 three cycles later:
  - WREADY=0 while waiting for AW; reg2 goes 0x00000000 -> 0x00220044.
  - Exactly one B response.
- Backpressure: BREADY=0 for 5 cycles after BVALID, and RREADY=0 for 4 cycles after RVALID:
  - BVALID/BRESP and RVALID/RDATA stay stable throughout.
  - AWREADY and ARREADY stay 0 until each handshake.
- Out-of-range write 0x20 and read 0x100, NUM_REGS=8:
  - No register changes and no reg_wr pulse.
  - With the macro, BRESP=RRESP=10 and RDATA=0; without it, both responses are 00.
- Collision: write 0xCAFEF00D to 0x0 with an AR to 0x0 handshaking in the W_EXEC cycle:
  - RDATA returns the old value 0.
  - A second read returns 0xCAFEF00D.
- Reset mid-transaction: assert rst while BVALID=1 and RVALID=1:
  - The next cycle shows all outputs 0 and reg_out=0.
  - Ready signals return 1 one cycle after rst drops.
